// File: rtl/code_loader_if.sv
// Byte-stream input and storage write port of the code loader.
// master: stream source and storage side; slave: the loader.
interface code_loader_if #(
   parameter int code_size = 12
);
   logic                 in_valid;
   logic [7:0]           in_data;
   logic                 in_ready;
   logic                 is_write;
   logic [31:0]          write_line;
   logic [code_size-1:0] write_data;

   modport master (
      output in_valid, in_data,
      input  in_ready, is_write, write_line, write_data
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, is_write, write_line, write_data
   );
endinterface

// File: rtl/code_loader.sv
// Loads a length-prefixed stream of big-endian code words into line storage.
// Define CODE_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module code_loader #(
   parameter int code_size     = 12,
   parameter int max_code_line = 100
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         error,
   code_loader_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      WORD_HI,
      WORD_LO,
`ifdef CODE_LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERROR
   } state_t;

   localparam logic [16:0] MAX_LINES = 17'(max_code_line + 1);

`ifdef CODE_LOADER_CHECKSUM_EN
   localparam state_t END_ST = CHK;
`else
   localparam state_t END_ST = DONE;
`endif

   state_t               state;
   state_t               state_nxt;
   logic [7:0]           len_hi;
   logic [15:0]          count;
   logic [15:0]          line_cnt;
   logic [code_size-9:0] word_hi;
   logic [15:0]          len_word;
   logic                 take;
   logic                 last_word;
`ifdef CODE_LOADER_CHECKSUM_EN
   logic [7:0]           csum;
`endif

   assign len_word  = {len_hi, bus.in_data};
   assign take      = bus.in_valid && bus.in_ready;
   assign last_word = (line_cnt + 16'd1) == count;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_nxt    = state;
      bus.in_ready = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      error        = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = LEN_HI;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = LEN_HI;
         end
         ERROR: begin
            error = 1'b1;
            if (start) state_nxt = LEN_HI;
         end
         LEN_HI: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
            if (bus.in_valid) state_nxt = LEN_LO;
         end
         LEN_LO: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
            if (bus.in_valid) begin
               if (len_word == 16'd0)                state_nxt = END_ST;
               else if ({1'b0, len_word} > MAX_LINES) state_nxt = ERROR;
               else                                  state_nxt = WORD_HI;
            end
         end
         WORD_HI: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
            if (bus.in_valid) state_nxt = WORD_LO;
         end
         WORD_LO: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
            if (bus.in_valid) state_nxt = last_word ? END_ST : WORD_HI;
         end
`ifdef CODE_LOADER_CHECKSUM_EN
         CHK: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
            if (bus.in_valid) state_nxt = (bus.in_data == csum) ? DONE : ERROR;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Byte capture, write strobe and counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.is_write   <= 1'b0;
         bus.write_line <= '0;
         bus.write_data <= '0;
         len_hi         <= '0;
         count          <= '0;
         line_cnt       <= '0;
         word_hi        <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
         csum           <= '0;
`endif
      end else begin
         bus.is_write <= 1'b0;
         if (!busy && start) begin
            line_cnt <= '0;
            count    <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
         end
         if (take) begin
            case (state)
               LEN_HI:  len_hi  <= bus.in_data;
               LEN_LO:  count   <= len_word;
               WORD_HI: word_hi <= bus.in_data[code_size-9:0];
               WORD_LO: begin
                  bus.is_write   <= 1'b1;
                  bus.write_line <= {16'd0, line_cnt};
                  bus.write_data <= {word_hi, bus.in_data};
                  line_cnt       <= line_cnt + 16'd1;
               end
               default: ;
            endcase
`ifdef CODE_LOADER_CHECKSUM_EN
            // The checksum byte itself is not folded into the running XOR
            if (state != CHK) csum <= csum ^ bus.in_data;
`endif
         end
      end
   end

endmodule

// File: tb/tb_code_loader.sv
// Directed self-checking bench for code_loader (max_code_line=100, code_size=12).
module tb_code_loader;

   typedef logic [7:0] bq_t[$];

   logic clk;
   logic reset;
   logic start;
   logic busy;
   logic done;
   logic error;

   int checks;
   int errors;

   int          wr_n;
   logic [31:0] wr_line[$];
   logic [11:0] wr_data[$];

   code_loader_if #(.code_size(12)) bus ();

   code_loader #(
      .code_size    (12),
      .max_code_line(100)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .busy (busy),
      .done (done),
      .error(error),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor: a one-cycle strobe is seen on exactly one falling edge
   always @(negedge clk) begin
      if (bus.is_write === 1'b1) begin
         wr_n = wr_n + 1;
         wr_line.push_back(bus.write_line);
         wr_data.push_back(bus.write_data);
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_data  = 8'h5A;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL send_timeout: in_ready stayed %b, required 1 (byte %h)", bus.in_ready, b);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input bq_t f, input int maxgap);
      foreach (f[i]) send_byte(f[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, required 0", error); end
      checks++; if (bus.is_write !== 1'b0) begin errors++; $display("FAIL reset_is_write: got %b, required 0", bus.is_write); end
      checks++; if (bus.write_line !== 32'd0) begin errors++; $display("FAIL reset_write_line: got %h, required 0", bus.write_line); end
      checks++; if (bus.write_data !== 12'd0) begin errors++; $display("FAIL reset_write_data: got %h, required 0", bus.write_data); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b, required 0", bus.in_ready); end
   endtask

   task automatic test_basic_load();
      bq_t f;
      int  base;
      base = wr_n;
      f = '{8'h00, 8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23};
`ifdef CODE_LOADER_CHECKSUM_EN
      f.push_back(8'h96);
`endif
      pulse_start();
      checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_busy_start: busy=%b in_ready=%b, required 1/1", busy, bus.in_ready); end
      send_frame(f, 0);
      repeat (3) @(negedge clk);
      checks++; if (wr_n - base !== 2) begin errors++; $display("FAIL basic_write_count: got %0d, required 2", wr_n - base); end
      if (wr_n - base == 2) begin
         checks++; if (wr_line[base] !== 32'd0 || wr_data[base] !== 12'hABC) begin errors++; $display("FAIL basic_write0: line %0d data %h, required 0 ABC", wr_line[base], wr_data[base]); end
         checks++; if (wr_line[base+1] !== 32'd1 || wr_data[base+1] !== 12'h123) begin errors++; $display("FAIL basic_write1: line %0d data %h, required 1 123", wr_line[base+1], wr_data[base+1]); end
      end
      checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL basic_done: done=%b error=%b, required 1/0", done, error); end
      checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%b in_ready=%b, required 0/0", busy, bus.in_ready); end
      checks++; if (bus.write_line !== 32'd1 || bus.write_data !== 12'h123 || bus.is_write !== 1'b0) begin errors++; $display("FAIL basic_hold: line %0d data %h is_write %b, required 1 123 0", bus.write_line, bus.write_data, bus.is_write); end
   endtask

`ifndef CODE_LOADER_CHECKSUM_EN
   task automatic test_zero_count();
      int base;
      base = wr_n;
      pulse_start();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_cleared: got %b, required 0", done); end
      send_frame('{8'h00, 8'h00}, 0);
      repeat (2) @(negedge clk);
      checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b error=%b, required 1/0", done, error); end
      checks++; if (wr_n !== base) begin errors++; $display("FAIL zero_no_write: got %0d writes, required 0", wr_n - base); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready: got %b, required 0", bus.in_ready); end
   endtask
`endif

   task automatic test_too_long();
      int base;
      base = wr_n;
      pulse_start();
      send_frame('{8'h00, 8'h66}, 0);
      repeat (2) @(negedge clk);
      checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL long_error: error=%b done=%b, required 1/0", error, done); end
      checks++; if (wr_n !== base) begin errors++; $display("FAIL long_no_write: got %0d writes, required 0", wr_n - base); end
      checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL long_in_ready: in_ready=%b busy=%b, required 0/0", bus.in_ready, busy); end
   endtask

   task automatic run_three_words(input string tag, input int maxgap);
      bq_t         f;
      int          base;
      logic [11:0] exp_d[3];
      exp_d = '{12'h111, 12'h222, 12'hFFF};
      base = wr_n;
      f = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h02, 8'h22};
      pulse_start();
      send_frame(f, maxgap);
      // A start while busy must not restart the load
      pulse_start();
      f = '{8'h0F, 8'hFF};
`ifdef CODE_LOADER_CHECKSUM_EN
      f.push_back(8'hD3);
`endif
      send_frame(f, maxgap);
      repeat (3) @(negedge clk);
      checks++; if (wr_n - base !== 3) begin errors++; $display("FAIL %s_write_count: got %0d, required 3", tag, wr_n - base); end
      if (wr_n - base == 3) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_line[base+i] !== 32'(i) || wr_data[base+i] !== exp_d[i]) begin
               errors++;
               $display("FAIL %s_write%0d: line %0d data %h, required %0d %h", tag, i, wr_line[base+i], wr_data[base+i], i, exp_d[i]);
            end
         end
      end
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s_done: done=%b busy=%b, required 1/0", tag, done, busy); end
   endtask

   task automatic test_back_to_back();
      run_three_words("b2b", 0);
   endtask

   task automatic test_random_valid();
      run_three_words("rnd", 3);
   endtask

   task automatic test_reset_mid_load();
      int base;
      base = wr_n;
      pulse_start();
      send_frame('{8'h00, 8'h02, 8'h0A, 8'hBC, 8'h01}, 0);
      #2;
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy=%b in_ready=%b, required 0/0", busy, bus.in_ready); end
      checks++; if (bus.write_line !== 32'd0 || bus.write_data !== 12'd0 || bus.is_write !== 1'b0) begin errors++; $display("FAIL midrst_outputs: line %0d data %h is_write %b, required 0 0 0", bus.write_line, bus.write_data, bus.is_write); end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL midrst_partial_write: got %0d writes, required 1", wr_n - base); end
      checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL midrst_flags: done=%b error=%b, required 0/0", done, error); end
      base = wr_n;
      pulse_start();
      send_frame('{8'h00, 8'h01, 8'h0A, 8'hBC}, 0);
`ifdef CODE_LOADER_CHECKSUM_EN
      send_byte(8'hB7, 0);
`endif
      repeat (2) @(negedge clk);
      checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL reload_count: got %0d writes, required 1", wr_n - base); end
      else begin
         checks++; if (wr_line[base] !== 32'd0 || wr_data[base] !== 12'hABC) begin errors++; $display("FAIL reload_write0: line %0d data %h, required 0 ABC", wr_line[base], wr_data[base]); end
      end
   endtask

`ifdef CODE_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int base;
      base = wr_n;
      pulse_start();
      send_frame('{8'h00, 8'h01, 8'h0A, 8'hBC, 8'hB7}, 0);
      repeat (2) @(negedge clk);
      checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL chk_good: done=%b error=%b, required 1/0", done, error); end
      checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL chk_good_writes: got %0d, required 1", wr_n - base); end
      base = wr_n;
      pulse_start();
      send_frame('{8'h00, 8'h01, 8'h0A, 8'hBC, 8'h00}, 0);
      repeat (2) @(negedge clk);
      checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL chk_bad: error=%b done=%b, required 1/0", error, done); end
      checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL chk_bad_writes: got %0d, required 1", wr_n - base); end
   endtask
`endif

   initial begin
      checks       = 0;
      errors       = 0;
      wr_n         = 0;
      start        = 1'b0;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      test_reset();
      test_basic_load();
`ifndef CODE_LOADER_CHECKSUM_EN
      test_zero_count();
`endif
      test_too_long();
      test_back_to_back();
      test_random_valid();
      test_reset_mid_load();
`ifdef CODE_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
